// File: rtl/prio_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module : prio_enc_pkg
// Brief  : Shared width constants for the 64-bit one-hot priority encoder.
// Rev    : 1.0  initial release
// ============================================================================
package prio_enc_pkg;

    localparam int IN_W   = 64;
    localparam int LEAF_W = 4;
    localparam int N_GRP  = 16;

endpackage
`default_nettype wire

// File: rtl/or4.sv
`default_nettype none
// ============================================================================
// Module : or4
// Brief  : 4-input OR reduction over one nibble.
// Rev    : 1.0  initial release
// ============================================================================
module or4
    import prio_enc_pkg::*;
(
    input  logic [LEAF_W-1:0] i_vec,
    output logic              o_any
);

    assign o_any = |i_vec;

endmodule
`default_nettype wire

// File: rtl/pe16b.sv
`default_nettype none
// ============================================================================
// Module : pe16b
// Brief  : 16-bit one-hot priority encoder built as a nibble tree of pe4b/or4.
// Rev    : 1.0  initial release
// ============================================================================
module pe16b
    import prio_enc_pkg::*;
(
    input  logic [4*LEAF_W-1:0] i_vec,
    output logic [4*LEAF_W-1:0] o_vec
);

    logic [4*LEAF_W-1:0] w_leaf;
    logic [3:0]          w_grp;
    logic [3:0]          w_sel;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_nib
            pe4b u_leaf (
                .i_vec (i_vec[LEAF_W*k +: LEAF_W]),
                .o_vec (w_leaf[LEAF_W*k +: LEAF_W])
            );

            or4 u_or (
                .i_vec (i_vec[LEAF_W*k +: LEAF_W]),
                .o_any (w_grp[k])
            );

            // Only the winning nibble's local one-hot survives.
            assign o_vec[LEAF_W*k +: LEAF_W] = w_leaf[LEAF_W*k +: LEAF_W] & {LEAF_W{w_sel[k]}};
        end
    endgenerate

    pe4b u_sel (
        .i_vec (w_grp),
        .o_vec (w_sel)
    );

endmodule
`default_nettype wire

// File: rtl/pe4b.sv
`default_nettype none
// ============================================================================
// Module : pe4b
// Brief  : 4-bit one-hot priority encoder, bit 3 wins; zero in gives zero out.
// Rev    : 1.0  initial release
// ============================================================================
module pe4b
    import prio_enc_pkg::*;
(
    input  logic [LEAF_W-1:0] i_vec,
    output logic [LEAF_W-1:0] o_vec
);

    assign o_vec[3] = i_vec[3];
    assign o_vec[2] = i_vec[2] & ~i_vec[3];
    assign o_vec[1] = i_vec[1] & ~(|i_vec[3:2]);
    assign o_vec[0] = i_vec[0] & ~(|i_vec[3:1]);

endmodule
`default_nettype wire

// File: rtl/prio_enc64_onehot.sv
`default_nettype none
// ============================================================================
// Module : prio_enc64_onehot
// Brief  : 64-bit one-hot priority encoder, two-stage pipeline (leaf, group).
// Rev    : 1.0  initial release
// ============================================================================
module prio_enc64_onehot
    import prio_enc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IN_W-1:0] in,
    output logic [IN_W-1:0] out,
    output logic            any
);

    logic [IN_W-1:0]  w_leaf;
    logic [N_GRP-1:0] w_grp;
    logic [IN_W-1:0]  r_leaf;
    logic [N_GRP-1:0] r_grp;
    logic [N_GRP-1:0] w_sel;
    logic [IN_W-1:0]  w_out;

    generate
        for (genvar k = 0; k < N_GRP; k++) begin : g_leaf
            pe4b u_leaf (
                .i_vec (in[LEAF_W*k +: LEAF_W]),
                .o_vec (w_leaf[LEAF_W*k +: LEAF_W])
            );

            or4 u_or (
                .i_vec (in[LEAF_W*k +: LEAF_W]),
                .o_any (w_grp[k])
            );
        end
    endgenerate

    // Leaf and group flags register together so a vector never mixes with its neighbour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_leaf <= '0;
            r_grp  <= '0;
        end else begin
            r_leaf <= w_leaf;
            r_grp  <= w_grp;
        end
    end

    pe16b u_grp_sel (
        .i_vec (r_grp),
        .o_vec (w_sel)
    );

    generate
        for (genvar k = 0; k < N_GRP; k++) begin : g_mask
            assign w_out[LEAF_W*k +: LEAF_W] = r_leaf[LEAF_W*k +: LEAF_W] & {LEAF_W{w_sel[k]}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= '0;
            any <= 1'b0;
        end else begin
            out <= w_out;
            any <= |r_grp;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prio_enc64_onehot.sv
`default_nettype none
// ============================================================================
// Module : tb_prio_enc64_onehot
// Brief  : Scoreboard bench for prio_enc64_onehot with a highest-bit reference.
// Rev    : 1.0  initial release
// ============================================================================
module tb_prio_enc64_onehot;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] din = '0;
    logic [63:0] dout;
    logic        dany;

    typedef struct {
        logic [63:0] src;
        logic [63:0] out;
        logic        any;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    prio_enc64_onehot dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (din),
        .out   (dout),
        .any   (dany)
    );

    function automatic logic [63:0] ref_onehot(input logic [63:0] v);
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) return 64'd1 << i;
        end
        return 64'd0;
    endfunction

    task automatic apply_exp(input logic [63:0] v, input logic r, input logic [63:0] eo);
        exp_t e;
        @(negedge clk);
        din   = v;
        rst_n = r;
        e.src = v;
        e.out = r ? eo : 64'd0;
        e.any = r && (v != 64'd0);
        sb.push_back(e);
    endtask

    task automatic apply(input logic [63:0] v, input logic r);
        apply_exp(v, r, ref_onehot(v));
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Monitor: the entry pushed one edge earlier is the one now at the output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                if (!rst_n) begin
                    e.out = 64'd0;
                    e.any = 1'b0;
                end
                checks++;
                if (dout !== e.out) begin
                    errors++;
                    $display("FAIL out: got %h want %h (in %h)", dout, e.out, e.src);
                end
                checks++;
                if (dany !== e.any) begin
                    errors++;
                    $display("FAIL any: got %b want %b (in %h)", dany, e.any, e.src);
                end
                checks++;
                if (!$onehot0(dout)) begin
                    errors++;
                    $display("FAIL onehot0: got %h", dout);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [63:0] v;

        repeat (3) apply(rand64(), 1'b0);

        repeat (3) apply_exp(64'h1664_3330_00F0_3F00, 1'b1, 64'h1000_0000_0000_0000);
        repeat (3) apply_exp(64'h5664_3330_00F0_3F00, 1'b1, 64'h4000_0000_0000_0000);
        repeat (3) apply_exp(64'h0004_3330_00F0_3F00, 1'b1, 64'h0004_0000_0000_0000);
        repeat (3) apply_exp(64'h0000_0030_00F0_3F00, 1'b1, 64'h0000_0020_0000_0000);
        repeat (3) apply_exp(64'h0, 1'b1, 64'h0);
        repeat (3) apply_exp(64'h1, 1'b1, 64'h1);
        repeat (3) apply_exp(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000);

        for (int i = 0; i < 64; i++) begin
            v = 64'd1 << i;
            apply_exp(v, 1'b1, v);
        end

        for (int n = 0; n < 10000; n++) begin
            case ($urandom_range(0, 3))
                0: v = rand64();
                1: v = (rand64() & rand64() & rand64()) >> $urandom_range(0, 63);
                2: v = 64'd1 << $urandom_range(0, 63);
                default: v = ($urandom_range(0, 7) == 0) ? 64'd0 : (rand64() >> $urandom_range(0, 63));
            endcase
            // Occasional mid-stream reset to flush in-flight vectors.
            if (n % 2500 == 1234) begin
                apply(rand64(), 1'b0);
                apply(rand64(), 1'b0);
            end
            apply(v, 1'b1);
        end

        repeat (3) apply(64'd0, 1'b1);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
